seg7_scan_display: RTL and testbench

- Downstream consumer of the CPU driver's four debug nibbles: PC, opcode, ALU result, memory output.
- Time-multiplexes the nibbles as hex digits onto the Nexys 4 common-anode seven-segment display.
- Runs on the raw board clock. Takes frame-aligned snapshots so a value changing mid-scan never shows torn digits.
- Provides a Freeze hold so the operator can read a value while the slowed CPU keeps stepping.

---
 rtl/seg7_scan_display.sv | 70 +++++++
 tb/tb_seg7_scan_display.sv | 115 +++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: frame-snapshotted 4-digit hex scan of PC/Ins/ALU/Mem onto a common-anode 7-seg display, with freeze hold and blanking
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       Clk_100MHz,
  input  logic       Reset,
  input  logic [3:0] PC_4bit,
  input  logic [3:0] Ins_4bit,
  input  logic [3:0] ALU_Out_4bit,
  input  logic [3:0] Mem_Out_4bit,
  input  logic [3:0] Blank_Mask,
  input  logic       Freeze,
  output logic [7:0] Anode,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic       Frame_Tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0] pre;
  logic [1:0] idx;
  logic [15:0] snap;
  logic run, tick, lit;
  logic [3:0] nib;
  logic [6:0] dec;
  always_comb begin
    tick = pre == PW'(REFRESH_DIV - 1);
    lit = run && !tick && !Blank_Mask[idx];
    nib = snap[{idx, 2'b00} +: 4];
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = 7'h7F;
    endcase
  end
  always_ff @(posedge Clk_100MHz or negedge Reset)
    if (!Reset) begin
      pre <= '0;
      idx <= 2'd3;
      snap <= 16'h0000;
      run <= 1'b0;
      Anode <= 8'hFF;
      Seg <= 7'h7F;
      Dp <= 1'b1;
      Frame_Tick <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      idx <= tick ? idx + 2'd1 : idx;
      run <= run | tick;
      snap <= (tick && idx == 2'd3 && !Freeze) ? {PC_4bit, Ins_4bit, ALU_Out_4bit, Mem_Out_4bit} : snap;
      Frame_Tick <= tick && idx == 2'd3 && !Freeze;
      Anode <= lit ? ~(8'h01 << idx) : 8'hFF;
      Seg <= lit ? dec : 7'h7F;
      Dp <= !(lit && idx == 2'd0 && Freeze);
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: randomized check of seg7_scan_display against a slot-arithmetic reference model
module tb_seg7_scan_display;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, frz = 1'b0;
  logic [3:0] pc = 4'd0, ins = 4'd0, alu = 4'd0, mem = 4'd0, mask = 4'd0;
  logic [7:0] anode;
  logic [6:0] seg;
  logic dp, ft;
  int vecs = 0, errs = 0;
  int n = 0;
  logic [15:0] snap = 16'h0;
  logic [6:0] hex [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  seg7_scan_display #(.REFRESH_DIV(N)) dut (
    .Clk_100MHz(clk), .Reset(rst_n), .PC_4bit(pc), .Ins_4bit(ins),
    .ALU_Out_4bit(alu), .Mem_Out_4bit(mem), .Blank_Mask(mask), .Freeze(frz),
    .Anode(anode), .Seg(seg), .Dp(dp), .Frame_Tick(ft)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at n=%0d: got %h, expected %h", tag, n, got, exp);
    end
  endtask
  // n = clock edges since reset release; slot s = n/N, a slot's first cycle (n%N==0) is dark
  task automatic step();
    int s, d;
    logic [7:0] ea;
    logic [6:0] es;
    logic ef;
    @(posedge clk);
    s = 0;
    ef = 1'b0;
    ea = 8'hFF;
    es = 7'h7F;
    if (!rst_n) begin
      n = 0;
      snap = 16'h0;
    end else begin
      n++;
      s = n / N;
      if (n % N == 0 && s % 4 == 1 && !frz) begin
        snap = {pc, ins, alu, mem};
        ef = 1'b1;
      end
      d = (s + 3) % 4;
      if (s > 0 && n % N != 0 && !mask[d]) begin
        ea = ~(8'h01 << d);
        es = hex[snap[d*4 +: 4]];
      end
    end
    #1;
    check("anode", 16'(anode), 16'(ea));
    check("seg", 16'(seg), 16'(es));
    check("frame_tick", 16'(ft), 16'(ef));
    check("dp", 16'(dp), 16'(!(ea[0] == 1'b0 && frz)));
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  initial begin
    int guard;
    {pc, ins, alu, mem} = 16'h1234;
    run(3);
    rst_n = 1'b1;
    run(4 + 16 * 2);
    guard = 0;
    while (!(n % N == 2 && (n / N + 3) % 4 == 2 && n / N > 0) && guard < 64) begin
      step();
      guard++;
    end
    check("digit2_reached", 16'(guard < 64), 16'd1);
    alu = 4'hF;
    run(40);
    frz = 1'b1;
    {pc, ins, alu, mem} = 16'h8888;
    run(40);
    frz = 1'b0;
    run(40);
    mask = 4'b1010;
    run(32);
    mask = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) {pc, ins, alu, mem} = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 20) == 0) frz = ~frz;
      step();
    end
    frz = 1'b0;
    mask = 4'b0000;
    {pc, ins, alu, mem} = 16'h5A3C;
    run(20);
    guard = 0;
    while (!(n % N == 2 && (n / N + 3) % 4 == 2 && n / N > 0) && guard < 64) begin
      step();
      guard++;
    end
    check("digit2_before_reset", 16'(anode), 16'hFB);
    #2 rst_n = 1'b0;
    #1;
    check("async_anode", 16'(anode), 16'hFF);
    check("async_seg", 16'(seg), 16'h7F);
    check("async_dp", 16'(dp), 16'd1);
    run(2);
    rst_n = 1'b1;
    {pc, ins, alu, mem} = 16'hE0D7;
    run(40);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
